// File: rtl/pipe_pkg.sv
// Shared constants and sweep-FSM state type for the pipeline register file.
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 32;
  localparam int unsigned PIPE_ADDR_W = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port with write-to-read bypass and busy lookup.
module rf_read_port
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned ADDR_W = PIPE_ADDR_W
) (
  input  logic [ADDR_W-1:0]                   rd_addr_i,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]    rf_i,
  input  logic [2**ADDR_W-1:0]                busy_i,
  input  logic                                byp_en_i,
  input  logic [ADDR_W-1:0]                   byp_addr_i,
  input  logic [DATA_W-1:0]                   byp_data_i,
  output logic [DATA_W-1:0]                   rd_data_o,
  output logic                                rd_busy_o
);

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = 1'b0;
    if (rd_addr_i != '0) begin
      if (byp_en_i && (byp_addr_i == rd_addr_i)) begin
        rd_data_o = byp_data_i;
      end else begin
        rd_data_o = rf_i[rd_addr_i];
        rd_busy_o = busy_i[rd_addr_i];
      end
    end
  end

endmodule

// File: rtl/pipe_regfile_sb.sv
// Pipeline register file: N read ports, one writeback port with bypass,
// per-register busy scoreboard, zero-sweep engine and a debug read tap.
module pipe_regfile_sb
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned ADDR_W = PIPE_ADDR_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  input  logic                       flush,
  input  logic                       clr_start,
  output logic                       clr_busy,
  input  logic [ADDR_W-1:0]          dbg_addr,
  output logic [DATA_W-1:0]          dbg_data
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  sweep_state_e                   state_q, state_d;
  logic [ADDR_W-1:0]              ptr_q, ptr_d;
  logic [DEPTH-1:0][DATA_W-1:0]   rf_q;
  logic [DEPTH-1:0]               busy_q, busy_d;
  logic                           idle;
  logic                           wr_ok;
  logic                           byp_en;

  assign idle   = (state_q == ST_IDLE);
  assign wr_ok  = wr_en && idle && (wr_addr != '0);
  assign byp_en = (BYPASS != 0) && wr_en && idle;

  // Sweep FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Sweep FSM: next state; terminal compare keeps ptr from wrapping to 0
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_SWEEP;
          ptr_d   = ADDR_W'(1);
        end
      end
      ST_SWEEP: begin
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sweep FSM: outputs
  always_comb begin
    clr_busy = (state_q == ST_SWEEP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_q <= '0;
    end else if (!idle) begin
      rf_q[ptr_q] <= '0;
    end else if (wr_ok) begin
      rf_q[wr_addr] <= wr_data;
    end
  end

  // Priority per entry: flush, then issue (newer producer), then writeback/sweep
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (flush) begin
        busy_d[i] = 1'b0;
      end else if (idle && iss_en && (iss_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if ((idle && wr_en && (wr_addr == ADDR_W'(i))) ||
                   (!idle && (ptr_q == ADDR_W'(i)))) begin
        busy_d[i] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_port (
      .rd_addr_i  (rd_addr[k*ADDR_W +: ADDR_W]),
      .rf_i       (rf_q),
      .busy_i     (busy_q),
      .byp_en_i   (byp_en),
      .byp_addr_i (wr_addr),
      .byp_data_i (wr_data),
      .rd_data_o  (rd_data[k*DATA_W +: DATA_W]),
      .rd_busy_o  (rd_busy[k])
    );
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule
